amba_write_arbiter: RTL and testbench
=====================================

Name: amba_write_arbiter

Overview:
- Two-master arbiter and sequencer for the shared AMBA/AXI write channel (AW, W, B) in front of the FIFO-based write-channel slave.
- Grants one master per transaction using round-robin and locks the grant from address through data to write response.
- Counts W beats against the latched AWLEN, generates the slave-side WLAST itself, and flags master WLAST mismatches.
- Per-master ports are packed vectors: master k occupies bits [k*W +: W].

Parameters:
ID_W, 6, AWID width per master
ADDR_W, 33, AWADDR width per master
DATA_W, 8, WDATA width per master

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
m2i_AWID  in  2*ID_W  per-master write ID
m2i_AWADDR  in  2*ADDR_W  per-master address
m2i_AWLEN  in  8  per-master burst length, 4 bits each; beats = AWLEN+1
m2i_AWVALID  in  2  per-master address valid
i2m_AWREADY  out  2  per-master address ready
m2i_WDATA  in  2*DATA_W  per-master write data
m2i_WLAST  in  2  per-master last-beat indication (checked only)
m2i_WVALID  in  2  per-master data valid
i2m_WREADY  out  2  per-master data ready
i2m_BVALID  out  2  per-master response valid
i2m_BRESP  out  4  per-master response, 2 bits each
m2i_BREADY  in  2  per-master response ready
i2s_AWID/i2s_AWADDR/i2s_AWLEN  out  ID_W/ADDR_W/4  granted master's address fields
i2s_AWVALID  out  1  address valid to slave
s2i_AWREADY  in  1  address ready from slave
i2s_WDATA  out  DATA_W  granted master's write data
i2s_WLAST  out  1  generated last beat, high when beat_cnt == len
i2s_WVALID  out  1  data valid to slave
s2i_WREADY  in  1  data ready from slave
s2i_BVALID  in  1  response valid from slave
s2i_BRESP  in  2  response from slave
i2s_BREADY  out  1  response ready to slave
o_gnt  out  1  index of the currently granted master
o_busy  out  1  high whenever state != IDLE
o_wlast_err  out  1  sticky WLAST mismatch flag

Behaviour:
- State machine: IDLE, ADDR, DATA, RESP. Registers: grant g, rr pointer (preferred master), len[3:0], beat_cnt[3:0], err.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; g=0, pointer=0, len=0, beat_cnt=0, err=0.
  - All valid and ready outputs are 0, all data outputs are 0, o_busy=0.
- IDLE:
  - Only one master requesting: grant it.
  - Both masters requesting: grant the pointer master.
  - Transition to ADDR on the next edge. AWVALID to i2s_AWVALID latency is exactly 1 cycle.
- ADDR:
  - i2s_AWVALID = m2i_AWVALID[g]; AW fields are muxed from master g; i2m_AWREADY[g] = s2i_AWREADY.
  - On handshake: len = AWLEN[g], beat_cnt = 0, go to DATA.
  - If m2i_AWVALID[g] drops before the handshake: return to IDLE with the pointer unchanged.
- DATA:
  - i2s_WVALID = m2i_WVALID[g]; i2m_WREADY[g] = s2i_WREADY; i2s_WLAST = (beat_cnt == len).
  - On each beat handshake: if m2i_WLAST[g] != i2s_WLAST, set err.
  - On the handshake where beat_cnt == len: go to RESP. Otherwise beat_cnt increments.
  - beat_cnt never wraps (max len = 15, i.e. 16 beats).
- RESP:
  - i2m_BVALID[g] = s2i_BVALID; BRESP is routed to master g's slot; i2s_BREADY = m2i_BREADY[g].
  - On handshake: go to IDLE and set pointer = ~g.
- Non-granted master always sees AWREADY, WREADY and BVALID = 0, and its BRESP slot = 0.
- Slave-side valids are 0 outside their own state.
- No W beat is forwarded before the AW handshake. Back-to-back transactions incur 1 IDLE cycle.
- o_wlast_err stays set until reset.
- Reset mid-burst: immediate abort to IDLE. No response is generated for the aborted transaction.

Test Plan:
- Single master: M0 sends AWLEN=3, AWADDR=777, AWID=6, with 4 beats of data 10..13 and WLAST on beat 4 -> i2s_AWVALID 1 cycle after AWVALID; 4 beats forwarded; i2s_WLAST on beat 4 only; i2m_BVALID[0] with BRESP=0; err stays 0.
- Contention: M0 and M1 assert AWVALID in the same cycle after reset -> M0 granted first, M1 granted next, then M0 again, alternating across 4 transactions.
- Backpressure: s2i_WREADY toggles every cycle, AWLEN=7 -> exactly 8 beats forwarded, data order preserved, beat_cnt holds while stalled.
- WLAST error: M1 asserts WLAST on beat 2 of AWLEN=3 -> o_wlast_err=1 from the next cycle; burst still completes with 4 beats; flag persists afterwards.
- Reset during DATA after 2 beats -> all outputs 0 immediately; state is IDLE; a following M1 request is granted normally.
- Max length: AWLEN=15 -> 16 beats forwarded, i2s_WLAST on beat 16 only, then RESP and return to IDLE.

Source files
------------

// File: rtl/amba_write_arbiter.sv
// Two-master round-robin arbiter for a shared AXI write channel (AW, W, B).
// The grant is held from the address phase until the write response; WLAST to the slave is generated here.
module amba_write_arbiter #(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 33,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*ID_W-1:0]   m2i_AWID,
  input  logic [2*ADDR_W-1:0] m2i_AWADDR,
  input  logic [7:0]          m2i_AWLEN,
  input  logic [1:0]          m2i_AWVALID,
  output logic [1:0]          i2m_AWREADY,
  input  logic [2*DATA_W-1:0] m2i_WDATA,
  input  logic [1:0]          m2i_WLAST,
  input  logic [1:0]          m2i_WVALID,
  output logic [1:0]          i2m_WREADY,
  output logic [1:0]          i2m_BVALID,
  output logic [3:0]          i2m_BRESP,
  input  logic [1:0]          m2i_BREADY,
  output logic [ID_W-1:0]     i2s_AWID,
  output logic [ADDR_W-1:0]   i2s_AWADDR,
  output logic [3:0]          i2s_AWLEN,
  output logic                i2s_AWVALID,
  input  logic                s2i_AWREADY,
  output logic [DATA_W-1:0]   i2s_WDATA,
  output logic                i2s_WLAST,
  output logic                i2s_WVALID,
  input  logic                s2i_WREADY,
  input  logic                s2i_BVALID,
  input  logic [1:0]          s2i_BRESP,
  output logic                i2s_BREADY,
  output logic                o_gnt,
  output logic                o_busy,
  output logic                o_wlast_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0] r_state;
  logic       r_gnt;
  logic       r_ptr;
  logic [3:0] r_len;
  logic [3:0] r_beat;
  logic       r_err;

  logic              w_awvalid_g;
  logic [3:0]        w_awlen_g;
  logic [ID_W-1:0]   w_awid_g;
  logic [ADDR_W-1:0] w_awaddr_g;
  logic [DATA_W-1:0] w_wdata_g;
  logic              w_last;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;

  assign w_awvalid_g = m2i_AWVALID[r_gnt];
  assign w_awlen_g   = r_gnt ? m2i_AWLEN[7:4] : m2i_AWLEN[3:0];
  assign w_awid_g    = r_gnt ? m2i_AWID[2*ID_W-1:ID_W] : m2i_AWID[ID_W-1:0];
  assign w_awaddr_g  = r_gnt ? m2i_AWADDR[2*ADDR_W-1:ADDR_W] : m2i_AWADDR[ADDR_W-1:0];
  assign w_wdata_g   = r_gnt ? m2i_WDATA[2*DATA_W-1:DATA_W] : m2i_WDATA[DATA_W-1:0];
  assign w_last      = (r_beat == r_len);
  assign w_aw_hs     = (r_state == S_ADDR) && w_awvalid_g && s2i_AWREADY;
  assign w_w_hs      = (r_state == S_DATA) && m2i_WVALID[r_gnt] && s2i_WREADY;
  assign w_b_hs      = (r_state == S_RESP) && s2i_BVALID && m2i_BREADY[r_gnt];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_ptr   <= 1'b0;
      r_len   <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Single requester wins outright; on contention the pointer decides.
          if (|m2i_AWVALID) begin
            r_gnt   <= (&m2i_AWVALID) ? r_ptr : m2i_AWVALID[1];
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_aw_hs) begin
            r_len   <= w_awlen_g;
            r_beat  <= '0;
            r_state <= S_DATA;
          end else if (!w_awvalid_g) begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (w_w_hs) begin
            if (m2i_WLAST[r_gnt] != w_last) r_err <= 1'b1;
            if (w_last) r_state <= S_RESP;
            else        r_beat  <= r_beat + 4'd1;
          end
        end
        S_RESP: begin
          if (w_b_hs) begin
            r_ptr   <= ~r_gnt;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    i2m_AWREADY = '0;
    i2m_WREADY  = '0;
    i2m_BVALID  = '0;
    i2m_BRESP   = '0;
    i2s_AWID    = '0;
    i2s_AWADDR  = '0;
    i2s_AWLEN   = '0;
    i2s_AWVALID = 1'b0;
    i2s_WDATA   = '0;
    i2s_WLAST   = 1'b0;
    i2s_WVALID  = 1'b0;
    i2s_BREADY  = 1'b0;
    case (r_state)
      S_ADDR: begin
        i2s_AWVALID        = w_awvalid_g;
        i2s_AWID           = w_awid_g;
        i2s_AWADDR         = w_awaddr_g;
        i2s_AWLEN          = w_awlen_g;
        i2m_AWREADY[r_gnt] = s2i_AWREADY;
      end
      S_DATA: begin
        i2s_WVALID        = m2i_WVALID[r_gnt];
        i2s_WDATA         = w_wdata_g;
        i2s_WLAST         = w_last;
        i2m_WREADY[r_gnt] = s2i_WREADY;
      end
      S_RESP: begin
        i2m_BVALID[r_gnt] = s2i_BVALID;
        i2s_BREADY        = m2i_BREADY[r_gnt];
        if (r_gnt) i2m_BRESP[3:2] = s2i_BRESP;
        else       i2m_BRESP[1:0] = s2i_BRESP;
      end
      default: ;
    endcase
  end

  assign o_gnt       = r_gnt;
  assign o_busy      = (r_state != S_IDLE);
  assign o_wlast_err = r_err;

endmodule

// File: tb/tb_amba_write_arbiter.sv
// Bench for amba_write_arbiter: bus-functional masters and slave with a transaction-level model
// that predicts grants, routing, forwarded beats, generated WLAST and the sticky error flag.
module tb_amba_write_arbiter;

  typedef struct {
    logic [5:0]   id;
    logic [32:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
    int           bad;
  } txn_t;

  logic        clk;
  logic        reset;
  logic [11:0] m2i_AWID;
  logic [65:0] m2i_AWADDR;
  logic [7:0]  m2i_AWLEN;
  logic [1:0]  m2i_AWVALID;
  logic [1:0]  i2m_AWREADY;
  logic [15:0] m2i_WDATA;
  logic [1:0]  m2i_WLAST;
  logic [1:0]  m2i_WVALID;
  logic [1:0]  i2m_WREADY;
  logic [1:0]  i2m_BVALID;
  logic [3:0]  i2m_BRESP;
  logic [1:0]  m2i_BREADY;
  logic [5:0]  i2s_AWID;
  logic [32:0] i2s_AWADDR;
  logic [3:0]  i2s_AWLEN;
  logic        i2s_AWVALID;
  logic        s2i_AWREADY;
  logic [7:0]  i2s_WDATA;
  logic        i2s_WLAST;
  logic        i2s_WVALID;
  logic        s2i_WREADY;
  logic        s2i_BVALID;
  logic [1:0]  s2i_BRESP;
  logic        i2s_BREADY;
  logic        o_gnt;
  logic        o_busy;
  logic        o_wlast_err;

  amba_write_arbiter #(.ID_W(6), .ADDR_W(33), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .m2i_AWID(m2i_AWID), .m2i_AWADDR(m2i_AWADDR), .m2i_AWLEN(m2i_AWLEN),
    .m2i_AWVALID(m2i_AWVALID), .i2m_AWREADY(i2m_AWREADY),
    .m2i_WDATA(m2i_WDATA), .m2i_WLAST(m2i_WLAST), .m2i_WVALID(m2i_WVALID),
    .i2m_WREADY(i2m_WREADY), .i2m_BVALID(i2m_BVALID), .i2m_BRESP(i2m_BRESP),
    .m2i_BREADY(m2i_BREADY),
    .i2s_AWID(i2s_AWID), .i2s_AWADDR(i2s_AWADDR), .i2s_AWLEN(i2s_AWLEN),
    .i2s_AWVALID(i2s_AWVALID), .s2i_AWREADY(s2i_AWREADY),
    .i2s_WDATA(i2s_WDATA), .i2s_WLAST(i2s_WLAST), .i2s_WVALID(i2s_WVALID),
    .s2i_WREADY(s2i_WREADY), .s2i_BVALID(s2i_BVALID), .s2i_BRESP(s2i_BRESP),
    .i2s_BREADY(i2s_BREADY),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_wlast_err(o_wlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Bench-side masters
  txn_t q0[$];
  txn_t q1[$];
  txn_t cur[2];
  int   ph[2];
  int   wb[2];

  // Transaction-level reference model
  bit   m_free;
  int   m_g;
  int   m_ptr;
  int   m_stage;
  int   m_done;
  bit   m_err;
  int   glog[$];
  int   fwd;

  // Stimulus knobs
  int   wr_mode;
  bit   wr_tog;
  bit   mv_rand;
  bit   bresp_rand;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] beat(input txn_t t, input int i);
    return t.data[i*8 +: 8];
  endfunction

  function automatic txn_t mk(input logic [5:0] id, input logic [32:0] addr, input logic [3:0] len,
                              input int base, input int bad);
    txn_t t;
    t.id   = id;
    t.addr = addr;
    t.len  = len;
    t.bad  = bad;
    for (int i = 0; i < 16; i++) t.data[i*8 +: 8] = (base < 0) ? 8'($urandom) : 8'(base + i);
    return t;
  endfunction

  task automatic push(input int m, input txn_t t);
    if (m == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  function automatic bit idle_all();
    return (q0.size() == 0) && (q1.size() == 0) && (ph[0] == 0) && (ph[1] == 0) && m_free;
  endfunction

  task automatic clear_state();
    q0.delete();
    q1.delete();
    ph[0] = 0; ph[1] = 0; wb[0] = 0; wb[1] = 0;
    m_free = 1'b1; m_g = 0; m_ptr = 0; m_stage = 0; m_done = 0; m_err = 1'b0;
    glog.delete();
    fwd = 0;
  endtask

  task automatic drive_idle();
    m2i_AWID = '0; m2i_AWADDR = '0; m2i_AWLEN = '0; m2i_AWVALID = '0;
    m2i_WDATA = '0; m2i_WLAST = '0; m2i_WVALID = '0; m2i_BREADY = '0;
    s2i_AWREADY = 1'b0; s2i_WREADY = 1'b0; s2i_BVALID = 1'b0; s2i_BRESP = '0;
  endtask

  task automatic cycle();
    logic [1:0]   e_awready, e_wready, e_bvalid;
    logic [3:0]   e_bresp;
    logic [43:0]  e_aw;
    logic         e_awv, e_wv, e_wlast, e_bready;
    logic [7:0]   e_wdata;
    bit           req0, req1, aw_hs, w_hs, b_hs;
    logic [1:0]   awr, wr, bv;
    // Masters
    for (int k = 0; k < 2; k++) begin
      if (ph[k] == 0) begin
        if (k == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); ph[0] = 1; wb[0] = 0; end
        if (k == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); ph[1] = 1; wb[1] = 0; end
      end
      m2i_AWVALID[k]       = (ph[k] == 1);
      m2i_AWID[k*6 +: 6]   = (ph[k] >= 1) ? cur[k].id : 6'd0;
      m2i_AWADDR[k*33 +: 33] = (ph[k] >= 1) ? cur[k].addr : 33'd0;
      m2i_AWLEN[k*4 +: 4]  = (ph[k] >= 1) ? cur[k].len : 4'd0;
      m2i_WVALID[k]        = (ph[k] == 2) && (!mv_rand || ($urandom_range(0, 3) != 0));
      m2i_WDATA[k*8 +: 8]  = (ph[k] == 2) ? beat(cur[k], wb[k]) : 8'd0;
      m2i_WLAST[k]         = (ph[k] == 2) && ((cur[k].bad < 0) ? (wb[k] == int'(cur[k].len)) : (wb[k] == cur[k].bad));
      m2i_BREADY[k]        = (ph[k] == 3) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
    end
    // Slave
    s2i_AWREADY = 1'($urandom_range(0, 1));
    if (wr_mode == 0)      s2i_WREADY = 1'($urandom_range(0, 1));
    else if (wr_mode == 1) s2i_WREADY = wr_tog;
    else                   s2i_WREADY = 1'b1;
    wr_tog     = ~wr_tog;
    s2i_BVALID = (!m_free && m_stage == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    s2i_BRESP  = (s2i_BVALID && bresp_rand) ? 2'($urandom_range(0, 3)) : 2'b00;
    #1;
    // Expected outputs from the model
    e_awv = !m_free && m_stage == 0;
    e_awready = (e_awv && s2i_AWREADY) ? (2'b01 << m_g) : 2'b00;
    e_aw = e_awv ? {cur[m_g].id, cur[m_g].addr, cur[m_g].len, 1'b1} : 44'd0;
    e_wv = !m_free && m_stage == 1 && m2i_WVALID[m_g];
    e_wready = (!m_free && m_stage == 1 && s2i_WREADY) ? (2'b01 << m_g) : 2'b00;
    e_wdata = (!m_free && m_stage == 1) ? beat(cur[m_g], m_done) : 8'd0;
    e_wlast = !m_free && m_stage == 1 && (m_done == int'(cur[m_g].len));
    e_bvalid = (!m_free && m_stage == 2 && s2i_BVALID) ? (2'b01 << m_g) : 2'b00;
    e_bresp = (!m_free && m_stage == 2) ? ({2'b00, s2i_BRESP} << (2 * m_g)) : 4'd0;
    e_bready = !m_free && m_stage == 2 && m2i_BREADY[m_g];
    chk("aw", {i2m_AWREADY, i2s_AWID, i2s_AWADDR, i2s_AWLEN, i2s_AWVALID}, {e_awready, e_aw[43:1], e_awv});
    chk("w", {i2m_WREADY, i2s_WVALID, i2s_WDATA, i2s_WLAST}, {e_wready, e_wv, e_wdata, e_wlast});
    chk("b", {i2m_BVALID, i2m_BRESP, i2s_BREADY}, {e_bvalid, e_bresp, e_bready});
    chk("ctl", {o_gnt, o_busy, o_wlast_err}, {m_g[0], !m_free, m_err});
    // Advance model and masters on pre-edge values
    awr = i2m_AWREADY; wr = i2m_WREADY; bv = i2m_BVALID;
    req0 = (ph[0] == 1); req1 = (ph[1] == 1);
    if (m_free) begin
      if (req0 || req1) begin
        m_g = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
        m_free = 1'b0;
        m_stage = 0;
        glog.push_back(m_g);
      end
    end else begin
      aw_hs = m_stage == 0 && m2i_AWVALID[m_g] && s2i_AWREADY;
      w_hs  = m_stage == 1 && m2i_WVALID[m_g] && s2i_WREADY;
      b_hs  = m_stage == 2 && s2i_BVALID && m2i_BREADY[m_g];
      if (aw_hs) begin m_stage = 1; m_done = 0; end
      if (w_hs) begin
        fwd++;
        if (m2i_WLAST[m_g] != (m_done == int'(cur[m_g].len))) m_err = 1'b1;
        if (m_done == int'(cur[m_g].len)) m_stage = 2;
        else m_done++;
      end
      if (b_hs) begin m_free = 1'b1; m_ptr = 1 - m_g; end
    end
    for (int k = 0; k < 2; k++) begin
      if (ph[k] == 1 && awr[k]) ph[k] = 2;
      else if (ph[k] == 2 && m2i_WVALID[k] && wr[k]) begin
        wb[k]++;
        if (wb[k] > int'(cur[k].len)) ph[k] = 3;
      end else if (ph[k] == 3 && bv[k] && m2i_BREADY[k]) ph[k] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int max_cyc, input int stop_beats);
    int n = 0;
    while (n < max_cyc) begin
      if (stop_beats >= 0 && !m_free && m_stage == 1 && m_done == stop_beats) break;
      if (stop_beats < 0 && idle_all()) break;
      cycle();
      n++;
    end
    chk({tag, "_complete"}, (n < max_cyc), 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    clear_state();
    #1;
    chk("rst_outs", {i2m_AWREADY, i2m_WREADY, i2m_BVALID, i2m_BRESP, i2s_AWID, i2s_AWADDR, i2s_AWLEN,
                     i2s_AWVALID, i2s_WDATA, i2s_WLAST, i2s_WVALID, i2s_BREADY, o_gnt, o_busy, o_wlast_err}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] order;
    reset = 1'b0;
    wr_mode = 2; wr_tog = 1'b1; mv_rand = 1'b0; bresp_rand = 1'b0;
    drive_idle();
    clear_state();
    #2;
    do_reset();

    // Single master, fixed burst
    push(0, mk(6'd6, 33'd777, 4'd3, 10, -1));
    run("single", 200, -1);
    chk("single_beats", fwd, 4);
    chk("single_gnt", glog.size() == 1 && glog[0] == 0, 1'b1);
    chk("single_err", o_wlast_err, 1'b0);

    // Simultaneous requests alternate starting at master 0
    do_reset();
    wr_mode = 0; mv_rand = 1'b1; bresp_rand = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push(0, mk(6'($urandom), 33'($urandom), 4'($urandom_range(0, 3)), -1, -1));
      push(1, mk(6'($urandom), 33'($urandom), 4'($urandom_range(0, 3)), -1, -1));
    end
    run("contend", 800, -1);
    chk("contend_count", glog.size(), 4);
    order = 4'hf;
    if (glog.size() == 4) order = {glog[0][0], glog[1][0], glog[2][0], glog[3][0]};
    chk("contend_order", order, 4'b0101);

    // Toggling slave WREADY
    fwd = 0;
    wr_mode = 1; mv_rand = 1'b0;
    push(1, mk(6'd33, 33'h1_2345_6789, 4'd7, -1, -1));
    run("bp", 400, -1);
    chk("bp_beats", fwd, 8);

    // Early WLAST from master 1 on beat 2
    fwd = 0;
    wr_mode = 0; mv_rand = 1'b1;
    push(1, mk(6'd1, 33'd4096, 4'd3, 40, 1));
    run("wlast", 400, -1);
    chk("wlast_beats", fwd, 4);
    chk("wlast_err", o_wlast_err, 1'b1);

    // Longest burst; error flag must still be held
    fwd = 0;
    push(0, mk(6'd2, 33'd8, 4'd15, 100, -1));
    run("max", 800, -1);
    chk("max_beats", fwd, 16);
    chk("max_err_sticky", o_wlast_err, 1'b1);

    // Reset after two data beats, then a fresh master-1 request
    do_reset();
    wr_mode = 2; mv_rand = 1'b0;
    push(0, mk(6'd9, 33'd1000, 4'd7, 0, -1));
    run("abort", 200, 2);
    reset = 1'b0;
    #1;
    chk("abort_outs", {i2m_AWREADY, i2m_WREADY, i2m_BVALID, i2m_BRESP, i2s_AWID, i2s_AWADDR, i2s_AWLEN,
                       i2s_AWVALID, i2s_WDATA, i2s_WLAST, i2s_WVALID, i2s_BREADY, o_gnt, o_busy, o_wlast_err}, '0);
    drive_idle();
    clear_state();
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(1, mk(6'd17, 33'd55, 4'd2, 200, -1));
    run("post_abort", 200, -1);
    chk("post_abort_gnt", glog.size() == 1 && glog[0] == 1, 1'b1);
    chk("post_abort_beats", fwd, 3);

    // Random traffic from both masters
    do_reset();
    wr_mode = 0; mv_rand = 1'b1; bresp_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      txn_t t;
      t = mk(6'($urandom), 33'({$urandom, $urandom}), 4'($urandom_range(0, 15)), -1, -1);
      if ($urandom_range(0, 9) == 0) t.bad = $urandom_range(0, 15);
      push($urandom_range(0, 1), t);
    end
    run("random", 8000, -1);
    chk("random_count", glog.size(), 24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
